// File: rtl/sm_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encodings and address field helpers used by the top and the fill sequencer.
package sm_icache_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Extract an unsigned bit field [lsb +: width] from a word address.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb,
                                             input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Line-aligned base of a word address (offset bits cleared).
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int off_w);
    return (addr >> off_w) << off_w;
  endfunction

endpackage

// File: rtl/sm_icache_fill.sv
// Line refill sequencer: walks the ROM one word at a time with a programmable
// per-word wait and strobes each captured word to the cache arrays.
module sm_icache_fill
  import sm_icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int MEM_WAIT   = 2,
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic             flush,
  output logic             mem_rd,
  output logic [31:0]      mem_addr,
  output logic [31:0]      line_base,
  output logic             cap,
  output logic [OFF_W-1:0] cap_word,
  output logic             cap_last,
  output logic [0:0]       state
);

  localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  logic [WAIT_W-1:0] wait_cnt;
  logic [OFF_W-1:0]  word_cnt;
  logic              wait_done;

  assign wait_done = (wait_cnt == WAIT_W'(MEM_WAIT));
  // A flush in the capture cycle aborts the fill, so it must not strobe.
  assign cap       = (state == ST_FILL) && wait_done && !flush;
  assign cap_last  = cap && (word_cnt == OFF_W'(LINE_WORDS - 1));
  assign cap_word  = word_cnt;
  assign mem_rd    = (state == ST_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      line_base <= '0;
      mem_addr  <= '0;
      word_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FILL;
            line_base <= base;
            mem_addr  <= base;
            word_cnt  <= '0;
            wait_cnt  <= '0;
          end
        end
        default: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (wait_done) begin
            wait_cnt <= '0;
            word_cnt <= word_cnt + OFF_W'(1);
            if (cap_last) state <= ST_IDLE;
            else mem_addr <= line_base + 32'(word_cnt) + 32'd1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sm_icache.sv
// Direct-mapped instruction cache: same-cycle hits from flop arrays, line
// refill through sm_icache_fill on a miss, flush and saturating statistics.
module sm_icache
  import sm_icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 8,
  parameter int MEM_WAIT   = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ready,
  output logic [31:0]      cpu_rdata,
  input  logic             flush,
  output logic             mem_rd,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [0:0]       dbg_state
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES][LINE_WORDS];
  logic [LINES-1:0] valid;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic             hit, miss_start;
  logic [31:0]      line_base;
  logic             cap, cap_last;
  logic [OFF_W-1:0] cap_word;

  assign off  = OFF_W'(addr_field(cpu_addr, 0, OFF_W));
  assign idx  = IDX_W'(addr_field(cpu_addr, OFF_W, IDX_W));
  assign tag  = TAG_W'(addr_field(cpu_addr, OFF_W + IDX_W, TAG_W));
  assign fidx = IDX_W'(addr_field(line_base, OFF_W, IDX_W));
  assign ftag = TAG_W'(addr_field(line_base, OFF_W + IDX_W, TAG_W));

  // Flush masks the lookup so it always wins over a hit or a new miss.
  assign hit        = (dbg_state == ST_IDLE) && cpu_req && valid[idx] &&
                      (tag_arr[idx] == tag) && !flush;
  assign miss_start = (dbg_state == ST_IDLE) && cpu_req && !hit && !flush;
  assign cpu_ready  = hit;
  assign cpu_rdata  = hit ? data_arr[idx][off] : 32'd0;

  sm_icache_fill #(
    .LINE_WORDS(LINE_WORDS),
    .MEM_WAIT  (MEM_WAIT)
  ) u_fill (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (miss_start),
    .base     (line_align(cpu_addr, OFF_W)),
    .flush    (flush),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .line_base(line_base),
    .cap      (cap),
    .cap_word (cap_word),
    .cap_last (cap_last),
    .state    (dbg_state)
  );

  // Arrays hold no reset; valid bits alone decide what may hit.
  always_ff @(posedge clk) begin
    if (cap) data_arr[fidx][cap_word] <= mem_rdata;
    if (cap_last) tag_arr[fidx] <= ftag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (flush) valid <= '0;
      else if (cap_last) valid[fidx] <= 1'b1;
      if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_start && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sm_icache.sv
// Bench for sm_icache: default build checked against a line-level cache model,
// plus a small build (2-word lines, no wait, 2-bit counters) checked directly.
module tb_sm_icache;

  localparam int LW = 4;
  localparam int MW = 2;
  localparam int NL = 8;
  localparam int FILL_CYC = LW * (MW + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, flush = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready, mem_rd;
  logic [31:0] cpu_rdata, mem_addr, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;
  logic [0:0]  dbg_state;

  logic        req2 = 1'b0, flush2 = 1'b0;
  logic [31:0] addr2 = '0;
  logic        ready2, mem_rd2;
  logic [31:0] rdata2, mem_addr2, mem_rdata2;
  logic [1:0]  hit_cnt2, miss_cnt2;
  logic [0:0]  dbg_state2;

  int checks = 0;
  int errors = 0;

  // Line-level model of the default build
  bit          mvalid [NL];
  int unsigned mtag   [NL];
  logic [15:0] exp_hits, exp_miss;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign mem_rdata  = rom(mem_addr);
  assign mem_rdata2 = rom(mem_addr2);

  sm_icache dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .flush(flush),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  sm_icache #(.LINE_WORDS(2), .LINES(8), .MEM_WAIT(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req2), .cpu_addr(addr2),
    .cpu_ready(ready2), .cpu_rdata(rdata2), .flush(flush2),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2), .dbg_state(dbg_state2)
  );

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
  endfunction

  // One fetch of address a, held until it hits; wiggle scrambles req/addr during the fill.
  task automatic fetch(input logic [31:0] a, input bit wiggle);
    int          idx;
    int unsigned tg;
    logic [31:0] base;
    idx  = int'((a / LW) % NL);
    tg   = a / (LW * NL);
    base = a - (a % LW);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a; flush = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== exp_hits || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL counters @%0h: hit %0d miss %0d, expected hit %0d miss %0d",
               a, hit_cnt, miss_cnt, exp_hits, exp_miss);
    end
    if (!(mvalid[idx] && mtag[idx] == tg)) begin
      checks++;
      if (cpu_ready !== 1'b0 || cpu_rdata !== 32'd0) begin
        errors++;
        $display("FAIL miss_cycle @%0h: ready %b rdata %h, expected 0 0", a, cpu_ready, cpu_rdata);
      end
      if (exp_miss != 16'hFFFF) exp_miss++;
      for (int k = 0; k < FILL_CYC; k++) begin
        @(negedge clk);
        if (wiggle) begin
          cpu_req  = 1'($urandom_range(0, 1));
          cpu_addr = $urandom_range(0, 255);
        end
        #1;
        checks++;
        if (cpu_ready !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== base + 32'(k / (MW + 1))) begin
          errors++;
          $display("FAIL fill @%0h k=%0d: ready %b mem_rd %b mem_addr %h, expected 0 1 %h",
                   a, k, cpu_ready, mem_rd, mem_addr, base + 32'(k / (MW + 1)));
        end
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = a;
      #1;
    end
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== rom(a) || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL hit @%0h: ready %b rdata %h mem_rd %b, expected 1 %h 0",
               a, cpu_ready, cpu_rdata, mem_rd, rom(a));
    end
    if (exp_hits != 16'hFFFF) exp_hits++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 32'd0 || mem_rd !== 1'b0 || mem_addr !== 32'd0 ||
        hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready %b rdata %h mem_rd %b mem_addr %h hit %0d miss %0d st %b, expected all 0",
               cpu_ready, cpu_rdata, mem_rd, mem_addr, hit_cnt, miss_cnt, dbg_state);
    end
    checks++;
    if (ready2 !== 1'b0 || mem_rd2 !== 1'b0 || hit_cnt2 !== 2'd0 || miss_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_small: ready %b mem_rd %b hit %0d miss %0d, expected 0", ready2, mem_rd2,
               hit_cnt2, miss_cnt2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    exp_hits = '0;
    exp_miss = '0;
  endtask

  task automatic test_first_fill_and_hits();
    fetch(32'h0, 1'b0);
    for (int i = 1; i < 4; i++) fetch(32'(i), 1'b0);
  endtask

  task automatic test_conflict();
    logic [15:0] m0;
    m0 = miss_cnt;
    fetch(32'h00, 1'b0);
    fetch(32'h20, 1'b0);
    fetch(32'h00, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checks++;
    if (miss_cnt !== m0 + 16'd2) begin
      errors++;
      $display("FAIL conflict_misses: miss_cnt %0d, expected %0d", miss_cnt, m0 + 16'd2);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0; flush = 1'b1;
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL flush_idle_hit: ready %b rdata %h, expected 0 0", cpu_ready, cpu_rdata);
    end
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL flush_idle_nofill: mem_rd %b miss %0d, expected 0 %0d", mem_rd, miss_cnt, exp_miss);
    end
    model_clear();
    fetch(32'h0, 1'b0);
  endtask

  task automatic test_flush_fill();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h10;
    exp_miss++;
    repeat (4) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (mem_rd !== 1'b1 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill_cycle: mem_rd %b ready %b, expected 1 0", mem_rd, cpu_ready);
    end
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill_abort: mem_rd %b st %b, expected 0 0", mem_rd, dbg_state);
    end
    model_clear();
    fetch(32'h10, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h8;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || mem_rd !== 1'b0 || mem_addr !== 32'd0 ||
        dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fill: hit %0d miss %0d mem_rd %b mem_addr %h st %b, expected 0",
               hit_cnt, miss_cnt, mem_rd, mem_addr, dbg_state);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    exp_hits = '0;
    exp_miss = '0;
    fetch(32'h8, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) fetch($urandom_range(0, 127), n[0]);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== exp_hits || miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL random_counters: hit %0d miss %0d, expected %0d %0d", hit_cnt, miss_cnt,
               exp_hits, exp_miss);
    end
  endtask

  task automatic test_small_build();
    logic [31:0] a;
    @(negedge clk);
    req2 = 1'b1; addr2 = 32'h7;
    #1;
    checks++;
    if (ready2 !== 1'b0) begin
      errors++;
      $display("FAIL small_miss: ready %b, expected 0", ready2);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_rd2 !== 1'b1 || mem_addr2 !== 32'(6 + k) || ready2 !== 1'b0) begin
        errors++;
        $display("FAIL small_fill k=%0d: mem_rd %b mem_addr %h ready %b, expected 1 %h 0",
                 k, mem_rd2, mem_addr2, ready2, 32'(6 + k));
      end
    end
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      a = (h == 0) ? 32'h7 : 32'($urandom_range(6, 7));
      addr2 = a;
      #1;
      checks++;
      if (ready2 !== 1'b1 || rdata2 !== rom(a)) begin
        errors++;
        $display("FAIL small_hit %0d: ready %b rdata %h, expected 1 %h", h, ready2, rdata2, rom(a));
      end
    end
    @(negedge clk);
    req2 = 1'b0;
    #1;
    checks++;
    if (hit_cnt2 !== 2'd3 || miss_cnt2 !== 2'd1) begin
      errors++;
      $display("FAIL small_saturate: hit %0d miss %0d, expected 3 1", hit_cnt2, miss_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_first_fill_and_hits();
    test_conflict();
    test_flush_idle();
    test_flush_fill();
    test_reset_mid_fill();
    test_random();
    test_small_build();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
